// File: rtl/spatz_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spatz_boot_sequencer
//  Purpose  : Boot controller for the Spatz cluster. On a start request it
//             waits a settle time, writes the entry point into the cluster
//             boot-control register over a reqrsp master port, reads it back
//             to verify, retries on failure, then pulses debug_req on every
//             core to wake them.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          in   clock
//    rst_ni         in   asynchronous active-low reset
//    start_i        in   start request (level, sampled when not busy)
//    entry_point_i  in   32-bit boot address, captured on start
//    q_addr_o       out  request address
//    q_data_o       out  request write data
//    q_write_o      out  1 = write, 0 = read
//    q_strb_o       out  request byte strobes
//    q_valid_o      out  request valid
//    q_ready_i      in   request ready
//    p_data_i       in   response data
//    p_error_i      in   response error
//    p_valid_i      in   response valid
//    p_ready_o      out  response ready
//    debug_req_o    out  per-core wake-up request
//    busy_o         out  sequence in progress
//    done_o         out  sequence completed successfully
//    error_o        out  retries exhausted
//    retry_cnt_o    out  retries consumed in the current or last sequence
// ============================================================================
module spatz_boot_sequencer #(
  parameter int unsigned          AddrWidth       = 48,
  parameter int unsigned          DataWidth       = 64,
  parameter int unsigned          NumCores        = 4,
  // Cluster peripheral base plus the boot-control register offset.
  parameter logic [AddrWidth-1:0] BootCtrlAddr    = AddrWidth'(32'h5102_0048),
  parameter int unsigned          WaitCycles      = 1000,
  parameter int unsigned          WakePulseCycles = 1,
  parameter int unsigned          MaxRetries      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            entry_point_i,
  output logic [AddrWidth-1:0]   q_addr_o,
  output logic [DataWidth-1:0]   q_data_o,
  output logic                   q_write_o,
  output logic [DataWidth/8-1:0] q_strb_o,
  output logic                   q_valid_o,
  input  logic                   q_ready_i,
  input  logic [DataWidth-1:0]   p_data_i,
  input  logic                   p_error_i,
  input  logic                   p_valid_i,
  output logic                   p_ready_o,
  output logic [NumCores-1:0]    debug_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [((MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1)-1:0] retry_cnt_o
);

  // Retry counter width; kept at least one bit so MaxRetries = 0 still elaborates.
  localparam int unsigned     RetryW     = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(MaxRetries);
  localparam logic [RetryW-1:0] RetryOne   = RetryW'(1);

  // One shared down-counter serves both the settle wait and the wake pulse.
  localparam int unsigned   CntMax   = (WaitCycles > WakePulseCycles) ? WaitCycles : WakePulseCycles;
  localparam int unsigned   CntW     = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
  localparam logic [CntW-1:0] WaitLoad = CntW'(WaitCycles);
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakePulseCycles);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WAIT   = 4'd1,
    S_WR_REQ = 4'd2,
    S_WR_RSP = 4'd3,
    S_RD_REQ = 4'd4,
    S_RD_RSP = 4'd5,
    S_WAKE   = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_e;

  state_e          r_state;
  logic [31:0]     r_entry;
  logic [CntW-1:0] r_cnt;

  logic w_rd_match;
  logic w_can_retry;

  // Only the low 32 bits of the readback carry the register contents.
  assign w_rd_match  = (p_data_i[31:0] == r_entry);
  assign w_can_retry = (retry_cnt_o < RetryLimit);

  if (DataWidth > 32) begin : g_unused_upper
    logic unused_p_data_upper;
    assign unused_p_data_upper = ^p_data_i[DataWidth-1:32];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_entry     <= '0;
      r_cnt       <= '0;
      q_addr_o    <= '0;
      q_data_o    <= '0;
      q_write_o   <= 1'b0;
      q_strb_o    <= '0;
      q_valid_o   <= 1'b0;
      p_ready_o   <= 1'b0;
      debug_req_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      retry_cnt_o <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_entry     <= entry_point_i;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            retry_cnt_o <= '0;
            busy_o      <= 1'b1;
            if (WaitCycles > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WaitLoad;
            end else begin
              // No settle time: the write request is presented right away,
              // so the data comes straight from the input being captured.
              r_state   <= S_WR_REQ;
              q_valid_o <= 1'b1;
              q_write_o <= 1'b1;
              q_addr_o  <= BootCtrlAddr;
              q_data_o  <= DataWidth'(entry_point_i);
              q_strb_o  <= '1;
            end
          end
        end

        S_WAIT: begin
          if (r_cnt == CntOne) begin
            r_state   <= S_WR_REQ;
            q_valid_o <= 1'b1;
            q_write_o <= 1'b1;
            q_addr_o  <= BootCtrlAddr;
            q_data_o  <= DataWidth'(r_entry);
            q_strb_o  <= '1;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end

        S_WR_REQ, S_RD_REQ: begin
          if (q_ready_i) begin
            q_valid_o <= 1'b0;
            p_ready_o <= 1'b1;
            r_state   <= (r_state == S_WR_REQ) ? S_WR_RSP : S_RD_RSP;
          end
        end

        S_WR_RSP, S_RD_RSP: begin
          if (p_valid_i) begin
            p_ready_o <= 1'b0;
            if (!p_error_i && (r_state == S_WR_RSP)) begin
              r_state   <= S_RD_REQ;
              q_valid_o <= 1'b1;
              q_write_o <= 1'b0;
              q_addr_o  <= BootCtrlAddr;
              q_data_o  <= '0;
              q_strb_o  <= '0;
            end else if (!p_error_i && w_rd_match) begin
              r_state     <= S_WAKE;
              r_cnt       <= WakeLoad;
              debug_req_o <= '1;
            end else if (w_can_retry) begin
              // Failed write or verify: rewrite immediately, no settle wait.
              retry_cnt_o <= retry_cnt_o + RetryOne;
              r_state     <= S_WR_REQ;
              q_valid_o   <= 1'b1;
              q_write_o   <= 1'b1;
              q_addr_o    <= BootCtrlAddr;
              q_data_o    <= DataWidth'(r_entry);
              q_strb_o    <= '1;
            end else begin
              r_state <= S_ERROR;
              busy_o  <= 1'b0;
              error_o <= 1'b1;
            end
          end
        end

        S_WAKE: begin
          if (r_cnt == CntOne) begin
            r_state     <= S_DONE;
            debug_req_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
